// File: rtl/sdelay_line.sv
// sdelay_line: clocked, multi-channel, runtime-programmable delay line.
// Each of WIDTH independent channels is delayed by D clock cycles, where D is
// taken from dly (0 -> 1, values above DEPTH clamp to DEPTH). In transport
// mode every sampled transition is reproduced. In inertial mode the output
// only moves once the last D samples agree, so pulses shorter than D are
// swallowed. INVERT=1 complements the registered output.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset (deassertion synchronised by caller)
//   din   in   [WIDTH] channel inputs, sampled every edge
//   dly   in   [DW]    requested delay, takes effect on the sampling edge
//   mode  in   0 = transport, 1 = inertial
//   dout  out  [WIDTH] delayed (optionally inverted) outputs, registered
//   pend  out  [WIDTH] 1 = the last D samples are not all equal to the output
module sdelay_line #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned DEPTH  = 8,
    parameter bit          INVERT = 1'b0,
    parameter int unsigned DW     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic [DW-1:0]    dly,
    input  logic             mode,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] pend
);

    // The window for the current edge is {din, h[0..D-2]}, so the oldest
    // history stage is never observed; it is not stored.
    localparam int unsigned HD = (DEPTH > 1) ? DEPTH - 1 : 1;

    logic [WIDTH-1:0] h_q [HD];
    logic [WIDTH-1:0] h_d [HD];
    logic [WIDTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] pend_q, pend_d;

    logic [31:0]      d_n;
    logic [WIDTH-1:0] win [DEPTH];
    logic [WIDTH-1:0] tap;
    logic [WIDTH-1:0] all1;
    logic [WIDTH-1:0] all0;
    logic [WIDTH-1:0] uni;

    always_comb begin
        // Effective delay
        if (dly == '0) begin
            d_n = 32'd1;
        end else if (dly > DW'(DEPTH)) begin
            d_n = DEPTH;
        end else begin
            d_n = 32'(dly);
        end

        // win[k] = s_(t-k) for the edge being taken now
        win[0] = din;
        for (int unsigned k = 1; k < DEPTH; k++) begin
            win[k] = h_q[k-1];
        end

        h_d[0] = din;
        for (int unsigned k = 1; k < HD; k++) begin
            h_d[k] = h_q[k-1];
        end

        tap  = '0;
        all1 = '1;
        all0 = '1;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (k < d_n) begin
                all1 = all1 & win[k];
                all0 = all0 & ~win[k];
            end
            if (k == d_n - 32'd1) begin
                tap = win[k];
            end
        end
        uni = all1 | all0;

        if (mode) begin
            v_d = (uni & din) | (~uni & v_q);
        end else begin
            v_d = tap;
        end

        // A channel is pending when some sample in the window disagrees with v
        pend_d = (v_d & ~all1) | (~v_d & ~all0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < HD; k++) begin
                h_q[k] <= '0;
            end
            v_q    <= '0;
            pend_q <= '0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            pend_q <= pend_d;
        end
    end

    assign dout = v_q ^ {WIDTH{INVERT}};
    assign pend = pend_q;

endmodule

// File: tb/tb_sdelay_line.sv
module tb_sdelay_line;

    logic       clk = 1'b0;
    logic       rst, rst1;
    logic [3:0] din, din1;
    logic [3:0] dly, dly1;
    logic       mode, mode1;
    logic [3:0] dout, pend, dout1, pend1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdelay_line #(.WIDTH(4), .DEPTH(8), .INVERT(1'b0)) u0 (
        .clk(clk), .rst(rst), .din(din), .dly(dly), .mode(mode),
        .dout(dout), .pend(pend)
    );

    sdelay_line #(.WIDTH(4), .DEPTH(8), .INVERT(1'b1)) u1 (
        .clk(clk), .rst(rst1), .din(din1), .dly(dly1), .mode(mode1),
        .dout(dout1), .pend(pend1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din = 4'h0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 4'hF; dly = 4'd3; mode = 1'b0;
        tick();
        tick();
        checks++;
        if (dout !== 4'h0) begin
            errors++; $display("FAIL reset_dout: got %h expected %h", dout, 4'h0);
        end
        checks++;
        if (pend !== 4'h0) begin
            errors++; $display("FAIL reset_pend: got %h expected %h", pend, 4'h0);
        end
    endtask

    task automatic test_transport_step();
        logic [3:0] exp_d, exp_p;
        dly = 4'd3; mode = 1'b0;
        do_reset();
        tick();
        din = 4'hF;
        for (int k = 0; k < 5; k++) begin
            tick();
            exp_d = (k >= 2) ? 4'hF : 4'h0;
            exp_p = (k < 2) ? 4'hF : 4'h0;
            checks++;
            if (dout !== exp_d) begin
                errors++; $display("FAIL step_dout k=%0d: got %h expected %h", k, dout, exp_d);
            end
            checks++;
            if (pend !== exp_p) begin
                errors++; $display("FAIL step_pend k=%0d: got %h expected %h", k, pend, exp_p);
            end
        end
    endtask

    task automatic test_transport_pulse();
        logic exp_b;
        dly = 4'd3; mode = 1'b0;
        do_reset();
        din = 4'h1;
        for (int k = 0; k < 6; k++) begin
            tick();
            din = 4'h0;
            exp_b = (k == 2);
            checks++;
            if (dout !== {3'b000, exp_b}) begin
                errors++; $display("FAIL tpulse_dout k=%0d: got %h expected %h", k, dout, {3'b000, exp_b});
            end
        end
    endtask

    task automatic test_inertial_pulses();
        logic exp_d, exp_p;
        dly = 4'd3; mode = 1'b1;
        // 2-sample pulse: swallowed
        do_reset();
        din = 4'h2;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (k == 1) din = 4'h0;
            exp_p = (k <= 3);
            checks++;
            if (dout !== 4'h0) begin
                errors++; $display("FAIL ipulse2_dout k=%0d: got %h expected %h", k, dout, 4'h0);
            end
            checks++;
            if (pend !== {2'b00, exp_p, 1'b0}) begin
                errors++; $display("FAIL ipulse2_pend k=%0d: got %h expected %h", k, pend, {2'b00, exp_p, 1'b0});
            end
        end
        // 3-sample pulse: passes with width preserved
        do_reset();
        din = 4'h2;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 2) din = 4'h0;
            exp_d = (k >= 2 && k <= 4);
            exp_p = (k <= 1) || (k == 3) || (k == 4);
            checks++;
            if (dout !== {2'b00, exp_d, 1'b0}) begin
                errors++; $display("FAIL ipulse3_dout k=%0d: got %h expected %h", k, dout, {2'b00, exp_d, 1'b0});
            end
            checks++;
            if (pend !== {2'b00, exp_p, 1'b0}) begin
                errors++; $display("FAIL ipulse3_pend k=%0d: got %h expected %h", k, pend, {2'b00, exp_p, 1'b0});
            end
        end
    endtask

    task automatic test_delay_bounds();
        logic [3:0] exp_d;
        mode = 1'b0;
        // dly=0 behaves as D=1
        dly = 4'd0;
        do_reset();
        din = 4'hF;
        tick();
        checks++;
        if (dout !== 4'hF) begin
            errors++; $display("FAIL dly0_dout: got %h expected %h", dout, 4'hF);
        end
        checks++;
        if (pend !== 4'h0) begin
            errors++; $display("FAIL dly0_pend: got %h expected %h", pend, 4'h0);
        end
        // dly=15 clamps to DEPTH=8
        dly = 4'd15;
        do_reset();
        din = 4'hF;
        for (int k = 0; k < 10; k++) begin
            tick();
            exp_d = (k >= 7) ? 4'hF : 4'h0;
            checks++;
            if (dout !== exp_d) begin
                errors++; $display("FAIL dly15_dout k=%0d: got %h expected %h", k, dout, exp_d);
            end
        end
        // dly=8 exactly DEPTH, inertial, 7-sample pulse is swallowed
        dly = 4'd8; mode = 1'b1;
        do_reset();
        din = 4'h8;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == 6) din = 4'h0;
            checks++;
            if (dout !== 4'h0) begin
                errors++; $display("FAIL dly8_ipulse k=%0d: got %h expected %h", k, dout, 4'h0);
            end
        end
    endtask

    task automatic test_invert_async_reset();
        rst1 = 1'b1; din1 = 4'h0; dly1 = 4'd2; mode1 = 1'b1;
        tick();
        checks++;
        if (dout1 !== 4'hF) begin
            errors++; $display("FAIL inv_reset_dout: got %h expected %h", dout1, 4'hF);
        end
        checks++;
        if (pend1 !== 4'h0) begin
            errors++; $display("FAIL inv_reset_pend: got %h expected %h", pend1, 4'h0);
        end
        rst1 = 1'b0;
        tick();
        din1 = 4'h5;
        tick();
        checks++;
        if (dout1 !== 4'hF || pend1 !== 4'h5) begin
            errors++; $display("FAIL inv_first: got dout=%h pend=%h expected dout=%h pend=%h", dout1, pend1, 4'hF, 4'h5);
        end
        tick();
        checks++;
        if (dout1 !== 4'hA || pend1 !== 4'h0) begin
            errors++; $display("FAIL inv_settle: got dout=%h pend=%h expected dout=%h pend=%h", dout1, pend1, 4'hA, 4'h0);
        end
        din1 = 4'h0;
        tick();
        checks++;
        if (dout1 !== 4'hA || pend1 !== 4'h5) begin
            errors++; $display("FAIL inv_midpulse: got dout=%h pend=%h expected dout=%h pend=%h", dout1, pend1, 4'hA, 4'h5);
        end
        #2;
        rst1 = 1'b1;
        #1;
        checks++;
        if (dout1 !== 4'hF || pend1 !== 4'h0) begin
            errors++; $display("FAIL inv_async_rst: got dout=%h pend=%h expected dout=%h pend=%h", dout1, pend1, 4'hF, 4'h0);
        end
        tick();
        rst1 = 1'b0;
    endtask

    task automatic test_mode_switch();
        logic exp_b;
        dly = 4'd4; mode = 1'b1;
        do_reset();
        for (int j = 0; j < 12; j++) begin
            din = (j % 2 == 0) ? 4'h4 : 4'h0;
            if (j >= 8) mode = 1'b0;
            tick();
            exp_b = (j >= 8) ? (j % 2 == 1) : 1'b0;
            checks++;
            if (dout[2] !== exp_b) begin
                errors++; $display("FAIL mode_sw_dout j=%0d: got %b expected %b", j, dout[2], exp_b);
            end
            if (j < 8) begin
                checks++;
                if (pend[2] !== 1'b1) begin
                    errors++; $display("FAIL mode_sw_pend j=%0d: got %b expected %b", j, pend[2], 1'b1);
                end
            end
        end
    endtask

    initial begin
        rst1 = 1'b1; din1 = 4'h0; dly1 = 4'd2; mode1 = 1'b1;
        test_reset();
        test_transport_step();
        test_transport_pulse();
        test_inertial_pulses();
        test_delay_bounds();
        test_invert_async_reset();
        test_mode_switch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
